// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-stage definitions: op codes, bus size codes, FSM state encodings
// and small op-decode helpers.
package mem_access_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t IDLE = 2'd0;
  localparam mem_state_t ADDR = 2'd1;
  localparam mem_state_t DATA = 2'd2;
  localparam mem_state_t DONE = 2'd3;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Unknown ops fall through to word size, matching the word-read fallback.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SIZE_B;
      OP_LH, OP_LHU, OP_SH: op_size = SIZE_H;
      default:              op_size = SIZE_W;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational load alignment and sign/zero extension; shared with the
// writeback forwarding path.
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext = {24'h000000, byte_sel};
      OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext = {16'h0000, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: drives the req/addr_ok/data_ok data bus for
// the merged E-stage request, stalls until completion and returns load data.
//
// state | meaning
// IDLE  | no access in flight; a new request is presented directly
// ADDR  | request held on the bus waiting for addr_ok
// DATA  | address accepted, waiting for data_ok
// DONE  | access complete, E instruction still held by another stall
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        E_mem_en,
  input  logic        E_mem_ren,
  input  logic        E_mem_wen,
  input  logic [5:0]  E_mem_op,
  input  logic [31:0] E_mem_addr,
  input  logic [31:0] E_mem_wdata,
  input  logic        other_stall,
  output logic        E_mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] M_mem_rdata
);

  mem_state_t  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        is_load_q, is_load_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ext_rdata;

  load_extend u_load_extend (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .rdata   (data_rdata),
    .ext     (ext_rdata)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    is_load_d   = is_load_q;
    rdata_d     = rdata_q;
    data_req    = 1'b0;
    E_mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        data_req    = E_mem_en;
        E_mem_stall = E_mem_en;
        if (E_mem_en) state_d = data_addr_ok ? DATA : ADDR;
      end
      ADDR: begin
        data_req    = 1'b1;
        E_mem_stall = 1'b1;
        if (data_addr_ok) state_d = DATA;
      end
      DATA: begin
        E_mem_stall = !data_data_ok;
        if (data_data_ok) begin
          if (is_load_q) rdata_d = ext_rdata;
          state_d = other_stall ? DONE : IDLE;
        end
      end
      default: begin
        if (!other_stall) state_d = IDLE;
      end
    endcase
    // Capture op/alignment at the address handshake; the extender uses these.
    if (data_req && data_addr_ok) begin
      op_d      = E_mem_op;
      addr_lo_d = E_mem_addr[1:0];
      is_load_d = E_mem_ren || !op_is_store(E_mem_op);
    end
  end

  always_comb begin
    data_wr    = data_req && E_mem_wen;
    data_size  = op_size(E_mem_op);
    data_addr  = E_mem_addr;
    data_wdata = E_mem_wdata;
    data_wstrb = 4'b0000;
    case (E_mem_op)
      OP_SB: begin
        data_wdata = {4{E_mem_wdata[7:0]}};
        if (E_mem_wen) data_wstrb = 4'b0001 << E_mem_addr[1:0];
      end
      OP_SH: begin
        data_wdata = {2{E_mem_wdata[15:0]}};
        if (E_mem_wen) data_wstrb = E_mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        if (E_mem_wen) data_wstrb = 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 6'd0;
      addr_lo_q <= 2'd0;
      is_load_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_lo_q <= addr_lo_d;
      is_load_q <= is_load_d;
      rdata_q   <= rdata_d;
    end
  end

  assign M_mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: drives bus handshakes by hand and checks
// stall, bus outputs, FSM state and extended load data against fixed values.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        E_mem_en, E_mem_ren, E_mem_wen;
  logic [5:0]  E_mem_op;
  logic [31:0] E_mem_addr, E_mem_wdata;
  logic        other_stall;
  logic        E_mem_stall;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] M_mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .E_mem_en     (E_mem_en),
    .E_mem_ren    (E_mem_ren),
    .E_mem_wen    (E_mem_wen),
    .E_mem_op     (E_mem_op),
    .E_mem_addr   (E_mem_addr),
    .E_mem_wdata  (E_mem_wdata),
    .other_stall  (other_stall),
    .E_mem_stall  (E_mem_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_wstrb   (data_wstrb),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .M_mem_rdata  (M_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp);
    tick();
    E_mem_en = 1'b1; E_mem_ren = 1'b1; E_mem_wen = 1'b0;
    E_mem_op = op; E_mem_addr = addr; data_addr_ok = 1'b1;
    #1;
    chk({tag, "_stall_req"}, {31'd0, E_mem_stall}, 32'd1);
    tick();
    // Live op/addr are scrambled here: extension must use the latched values.
    E_mem_op = OP_LW; E_mem_addr = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
    #1;
    chk({tag, "_stall_data"}, {31'd0, E_mem_stall}, 32'd0);
    tick();
    E_mem_en = 1'b0; E_mem_ren = 1'b0; data_data_ok = 1'b0;
    #1;
    chk({tag, "_rdata"}, M_mem_rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    E_mem_en = 1'b0; E_mem_ren = 1'b0; E_mem_wen = 1'b0;
    E_mem_op = 6'd0; E_mem_addr = 32'd0; E_mem_wdata = 32'd0;
    other_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    tick();
    tick();
    #1;
    chk("rst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
    chk("rst_stall", {31'd0, E_mem_stall}, 32'd0);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_rdata", M_mem_rdata, 32'd0);
    rst = 1'b0;

    // LW, addr_ok in request cycle, data_ok next cycle
    tick();
    E_mem_en = 1'b1; E_mem_ren = 1'b1; E_mem_op = OP_LW; E_mem_addr = 32'h10;
    data_addr_ok = 1'b1;
    #1;
    chk("lw_req", {31'd0, data_req}, 32'd1);
    chk("lw_stall0", {31'd0, E_mem_stall}, 32'd1);
    chk("lw_size", {30'd0, data_size}, 32'd2);
    chk("lw_addr", data_addr, 32'h10);
    chk("lw_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk("lw_wr", {31'd0, data_wr}, 32'd0);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_state_data", {30'd0, dut.state_q}, {30'd0, DATA});
    chk("lw_stall1", {31'd0, E_mem_stall}, 32'd0);
    chk("lw_req_data", {31'd0, data_req}, 32'd0);
    tick();
    E_mem_en = 1'b0; E_mem_ren = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("lw_state_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
    chk("lw_rdata", M_mem_rdata, 32'hDEADBEEF);

    do_load("lb",  OP_LB,  32'h00000103, 32'h80FF1234, 32'hFFFFFF80);
    do_load("lbu", OP_LBU, 32'h00000103, 32'h80FF1234, 32'h00000080);
    do_load("lb0", OP_LB,  32'h00000100, 32'h80FF1234, 32'h00000034);
    do_load("lh",  OP_LH,  32'h00000102, 32'h80FF1234, 32'hFFFF80FF);

    // SB with data_ok two cycles after addr_ok
    tick();
    E_mem_en = 1'b1; E_mem_wen = 1'b1; E_mem_op = OP_SB; E_mem_addr = 32'h101;
    E_mem_wdata = 32'h000000AB; data_addr_ok = 1'b1;
    #1;
    chk("sb_wdata", data_wdata, 32'hABABABAB);
    chk("sb_wstrb", {28'd0, data_wstrb}, 32'b0010);
    chk("sb_wr", {31'd0, data_wr}, 32'd1);
    chk("sb_size", {30'd0, data_size}, 32'd0);
    tick();
    data_addr_ok = 1'b0;
    #1;
    chk("sb_stall_wait", {31'd0, E_mem_stall}, 32'd1);
    chk("sb_req_wait", {31'd0, data_req}, 32'd0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'h55555555;
    #1;
    chk("sb_stall_ok", {31'd0, E_mem_stall}, 32'd0);
    tick();
    E_mem_en = 1'b0; E_mem_wen = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("sb_rdata_kept", M_mem_rdata, 32'hFFFF80FF);

    // SH with addr_ok withheld for three cycles
    tick();
    E_mem_en = 1'b1; E_mem_wen = 1'b1; E_mem_op = OP_SH; E_mem_addr = 32'h22;
    E_mem_wdata = 32'h1234CDEF; data_addr_ok = 1'b0;
    #1;
    chk("sh_wdata", data_wdata, 32'hCDEFCDEF);
    chk("sh_wstrb", {28'd0, data_wstrb}, 32'b1100);
    chk("sh_size", {30'd0, data_size}, 32'd1);
    chk("sh_stall_idle", {31'd0, E_mem_stall}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("sh_state_addr", {30'd0, dut.state_q}, {30'd0, ADDR});
      chk("sh_req_held", {31'd0, data_req}, 32'd1);
      chk("sh_addr_held", data_addr, 32'h22);
      chk("sh_stall_addr", {31'd0, E_mem_stall}, 32'd1);
    end
    tick();
    data_addr_ok = 1'b1;
    #1;
    chk("sh_req_accept", {31'd0, data_req}, 32'd1);
    chk("sh_stall_accept", {31'd0, E_mem_stall}, 32'd1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    #1;
    chk("sh_state_data", {30'd0, dut.state_q}, {30'd0, DATA});
    chk("sh_stall_done", {31'd0, E_mem_stall}, 32'd0);
    tick();
    E_mem_en = 1'b0; E_mem_wen = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("sh_state_idle", {30'd0, dut.state_q}, {30'd0, IDLE});

    // LHU completes while another stall holds the instruction
    tick();
    E_mem_en = 1'b1; E_mem_ren = 1'b1; E_mem_op = OP_LHU; E_mem_addr = 32'h40;
    data_addr_ok = 1'b1; other_stall = 1'b1;
    #1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h12348001;
    #1;
    chk("done_stall_data", {31'd0, E_mem_stall}, 32'd0);
    tick();
    data_rdata = 32'hFFFFFFFF;
    #1;
    chk("done_state", {30'd0, dut.state_q}, {30'd0, DONE});
    chk("done_stall", {31'd0, E_mem_stall}, 32'd0);
    chk("done_no_req", {31'd0, data_req}, 32'd0);
    chk("done_rdata", M_mem_rdata, 32'h00008001);
    tick();
    data_data_ok = 1'b0; other_stall = 1'b0;
    #1;
    chk("done_hold", {30'd0, dut.state_q}, {30'd0, DONE});
    chk("done_spurious_ok", M_mem_rdata, 32'h00008001);
    tick();
    E_mem_en = 1'b0; E_mem_ren = 1'b0;
    #1;
    chk("done_to_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
    chk("done_rdata_kept", M_mem_rdata, 32'h00008001);

    // Reset while waiting in DATA
    tick();
    E_mem_en = 1'b1; E_mem_ren = 1'b1; E_mem_op = OP_LW; E_mem_addr = 32'h50;
    data_addr_ok = 1'b1;
    #1;
    tick();
    data_addr_ok = 1'b0; rst = 1'b1;
    #1;
    chk("rstmid_state_data", {30'd0, dut.state_q}, {30'd0, DATA});
    tick();
    rst = 1'b0; E_mem_en = 1'b0; E_mem_ren = 1'b0;
    #1;
    chk("rstmid_state", {30'd0, dut.state_q}, {30'd0, IDLE});
    chk("rstmid_stall", {31'd0, E_mem_stall}, 32'd0);
    chk("rstmid_rdata", M_mem_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
